// File: rtl/sm_ctrl_pkg.sv
// Shared definitions for the sign-magnitude adder sequencing controller.
//   state_t        : controller phases
//   BTN_*          : bit positions inside the debounced button vector
//   ERR_DISPLAY    : all-ones pattern shown while in ERR (slice to width)
//   is_neg_zero()  : detects -0 so operands can be stored as +0
package sm_ctrl_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    SHOW,
    ERR
  } state_t;

  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;
  localparam int BTN_VIEW  = 2;

  localparam logic [63:0] ERR_DISPLAY = '1;

  // True when v (zero-extended, w bits wide) is sign=1 with a zero magnitude.
  // The caller substitutes all zeros, so -0 and +0 are indistinguishable
  // downstream.
  function automatic logic is_neg_zero(input logic [63:0] v, input int unsigned w);
    logic [63:0] mag_mask;
    mag_mask = (64'd1 << (w - 1)) - 64'd1;
    return v[w-1] && ((v & mag_mask) == 64'd0);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for debounced button levels.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   lvl_i  : debounced button levels
//   rise_o : one-cycle pulse per bit on a 0->1 transition
// History resets to all ones so a button already held when reset releases
// produces no event until it is released and pressed again.
module btn_edge_detect #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] lvl_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= '1;
    else       prev_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/sm_adder_ctrl.sv
// Sequencing controller between the button debouncer and the sign-magnitude
// adder datapath.
//   clk_100Mhz : system clock
//   reset      : asynchronous active-high reset
//   btn_db     : debounced buttons [0]=ENTER [1]=CLEAR [2]=VIEW
//   sw         : switch value, sign-magnitude
//   op_a/op_b  : latched operands to the adder
//   add_start  : one-cycle start pulse to the adder
//   add_done   : adder result valid; add_sum/add_ovf qualified by it
//   disp_val   : value to display (combinational mux)
//   state_led  : one-hot phase [0]=entering A [1]=entering B [2]=result
//   err        : high while in ERR
module sm_adder_ctrl
  import sm_ctrl_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_100Mhz,
  input  logic             reset,
  input  logic [2:0]       btn_db,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             add_start,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_ovf,
  output logic [WIDTH-1:0] disp_val,
  output logic [2:0]       state_led,
  output logic             err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       rise;
  logic [WIDTH-1:0] sw_canon;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             view_q, view_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       led_q, led_d;
  logic             add_start_q;
  logic             err_q;

  btn_edge_detect #(.N(3)) u_edge (
    .clk_i  (clk_100Mhz),
    .rst_i  (reset),
    .lvl_i  (btn_db),
    .rise_o (rise)
  );

  assign sw_canon = is_neg_zero(64'(sw), WIDTH) ? '0 : sw;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    view_d   = view_q;
    cnt_d    = cnt_q;

    if (rise[BTN_CLEAR]) begin
      state_d  = LOAD_A;
      op_a_d   = '0;
      op_b_d   = '0;
      result_d = '0;
      view_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (rise[BTN_ENTER]) begin
            op_a_d  = sw_canon;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (rise[BTN_ENTER]) begin
            op_b_d  = sw_canon;
            state_d = START;
            // Counter holds 0 during the start-pulse cycle and counts cycles
            // since the pulse from then on, so ERR lands exactly
            // TIMEOUT_CYCLES cycles after add_start rose.
            cnt_d   = '0;
          end
        end
        START: begin
          state_d = WAIT;
          cnt_d   = cnt_q + 1'b1;
        end
        WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (add_done) begin
            if (add_ovf) begin
              state_d = ERR;
            end else begin
              result_d = add_sum;
              state_d  = SHOW;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = ERR;
          end
        end
        SHOW: begin
          if (rise[BTN_ENTER]) begin
            state_d = LOAD_A;
            view_d  = 1'b0;
          end else if (rise[BTN_VIEW]) begin
            view_d = ~view_q;
          end
        end
        ERR: begin
          if (rise[BTN_ENTER]) state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_comb begin
    led_d = 3'b000;
    unique case (state_d)
      LOAD_A:  led_d = 3'b001;
      LOAD_B:  led_d = 3'b010;
      SHOW:    led_d = 3'b100;
      default: led_d = 3'b000;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      view_q      <= 1'b0;
      cnt_q       <= '0;
      led_q       <= 3'b001;
      add_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      view_q      <= view_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      add_start_q <= (state_d == START);
      err_q       <= (state_d == ERR);
    end
  end

  // Display blanks while reset is held; otherwise follows the phase.
  always_comb begin
    disp_val = '0;
    if (!reset) begin
      unique case (state_q)
        LOAD_A, LOAD_B: disp_val = sw;
        START, WAIT:    disp_val = op_b_q;
        SHOW:           disp_val = view_q ? op_a_q : result_q;
        ERR:            disp_val = ERR_DISPLAY[WIDTH-1:0];
        default:        disp_val = '0;
      endcase
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign add_start = add_start_q;
  assign state_led = led_q;
  assign err       = err_q;

endmodule
